// File: rtl/mux_a_pkg.sv
// Shared types and default sizing for the registered A-operand mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_a_pkg;

    localparam int MUX_A_WIDTH   = 11;
    localparam int MUX_A_NUM_SRC = 4;
    localparam int MUX_A_TIMEOUT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mux_a_state_t;

endpackage

// File: rtl/mux_a_timer.sv
// WAIT-state cycle counter with expiry flag; cleared when WAIT is entered.
// Latency: expired is combinational from the count register.
// Backpressure: none; counts only while tick is high.
module mux_a_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Expiry marks the last permitted WAIT cycle, not one past it.
    assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mux_a_seq.sv
// Registered A-operand mux: selects a source, waits for its valid, captures into MA_out.
// Latency: 1 cycle from request when the source is valid, else up to TIMEOUT WAIT cycles.
// Backpressure: requests are ignored while busy_out is high; done/err pulses end each request.
module mux_a_seq
    import mux_a_pkg::*;
#(
    parameter int  WIDTH   = MUX_A_WIDTH,
    parameter int  NUM_SRC = MUX_A_NUM_SRC,
    parameter int  TIMEOUT = MUX_A_TIMEOUT,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_in,
    input  logic [SEL_W-1:0]         sel_A_in,
    input  logic [NUM_SRC*WIDTH-1:0] src_in,
    input  logic [NUM_SRC-1:0]       src_valid_in,
    output logic [WIDTH-1:0]         MA_out,
    output logic                     done_out,
    output logic                     err_out,
    output logic                     busy_out,
    output logic [SEL_W-1:0]         last_sel_out
);

    mux_a_state_t state_q, state_d;

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] cur_sel;
    logic [WIDTH-1:0] cur_dat;
    logic             sel_bad;
    logic             cur_vld;
    logic             expired;

    logic capture, fail, enter_wait, tick;

    logic [WIDTH-1:0] ma_q;
    logic [SEL_W-1:0] last_sel_q;
    logic             done_q, err_q;

    // In WAIT the latched select is authoritative; live sel_A_in is ignored.
    assign cur_sel = (state_q == IDLE) ? sel_A_in : sel_q;
    assign sel_bad = (int'(cur_sel) >= NUM_SRC);
    assign cur_vld = !sel_bad && src_valid_in[cur_sel];
    assign cur_dat = src_in[int'(cur_sel)*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_in && !sel_bad && !cur_vld) state_d = WAIT;
            WAIT: if (cur_vld || expired)             state_d = IDLE;
            default:                                  state_d = IDLE;
        endcase
    end

    always_comb begin
        capture    = 1'b0;
        fail       = 1'b0;
        enter_wait = 1'b0;
        tick       = 1'b0;
        case (state_q)
            IDLE: begin
                capture    = req_in && cur_vld;
                fail       = req_in && sel_bad;
                enter_wait = req_in && !sel_bad && !cur_vld;
            end
            WAIT: begin
                // Valid wins over timeout when both land on the same cycle.
                capture = cur_vld;
                fail    = !cur_vld && expired;
                tick    = !cur_vld && !expired;
            end
            default: ;
        endcase
    end

    mux_a_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (enter_wait),
        .tick    (tick),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ma_q       <= '0;
            last_sel_q <= '0;
            sel_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= capture;
            err_q  <= fail;
            if (capture) begin
                ma_q       <= cur_dat;
                last_sel_q <= cur_sel;
            end
            if (enter_wait) begin
                sel_q <= sel_A_in;
            end
        end
    end

    assign MA_out       = ma_q;
    assign done_out     = done_q;
    assign err_out      = err_q;
    assign busy_out     = (state_q == WAIT);
    assign last_sel_out = last_sel_q;

endmodule

// File: tb/tb_mux_a_seq.sv
// Randomised scoreboard bench for mux_a_seq against a transaction-level outcome model.
module tb_mux_a_seq;

    localparam int WIDTH   = 11;
    localparam int NUM_SRC = 4;
    localparam int TIMEOUT = 8;
    localparam int SEL_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     req_in;
    logic [SEL_W-1:0]         sel_A_in;
    logic [NUM_SRC*WIDTH-1:0] src_in;
    logic [NUM_SRC-1:0]       src_valid_in;
    logic [WIDTH-1:0]         MA_out;
    logic                     done_out;
    logic                     err_out;
    logic                     busy_out;
    logic [SEL_W-1:0]         last_sel_out;

    mux_a_seq #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_in       (req_in),
        .sel_A_in     (sel_A_in),
        .src_in       (src_in),
        .src_valid_in (src_valid_in),
        .MA_out       (MA_out),
        .done_out     (done_out),
        .err_out      (err_out),
        .busy_out     (busy_out),
        .last_sel_out (last_sel_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               is_done;
        logic [WIDTH-1:0] dat;
        logic [SEL_W-1:0] sel;
        int               busy;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int busy_cnt = 0;
    bit mon_en = 1'b0;
    logic rst_q;
    logic [WIDTH-1:0] mon_ma;
    logic [SEL_W-1:0] mon_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        rst_q <= rst_n;
    end

    // Monitor: pops one expectation per done/err pulse and checks hold behaviour otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_q) begin
                chk("rst_ma", 32'(MA_out), 0);
                chk("rst_done", 32'(done_out), 0);
                chk("rst_err", 32'(err_out), 0);
                chk("rst_busy", 32'(busy_out), 0);
                chk("rst_last_sel", 32'(last_sel_out), 0);
                mon_ma   = '0;
                mon_last = '0;
                busy_cnt = 0;
            end else begin
                chk("done_err_exclusive", 32'(done_out & err_out), 0);
                if (busy_out) busy_cnt++;
                if (done_out || err_out) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", 32'({done_out, err_out}), 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("pulse_kind_done", 32'(done_out), 32'(e.is_done));
                        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                        chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
                        if (e.is_done) begin
                            mon_ma   = e.dat;
                            mon_last = e.sel;
                        end
                    end
                    busy_cnt = 0;
                end
                chk("ma_value", 32'(MA_out), 32'(mon_ma));
                chk("last_sel", 32'(last_sel_out), 32'(mon_last));
            end
        end
    end

    task automatic drive_step(input int s, input bit vs, input bit rq, input int sl,
                              input bit fx, input logic [WIDTH-1:0] fv,
                              output logic [WIDTH-1:0] cap);
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        src_valid_in = NUM_SRC'($urandom);
        if (fx) src_in[s*WIDTH +: WIDTH] = fv;
        src_valid_in[s] = vs;
        req_in   = rq;
        sel_A_in = SEL_W'(sl);
        cap      = src_in[s*WIDTH +: WIDTH];
    endtask

    task automatic idle(input int n);
        logic [WIDTH-1:0] cap;
        for (int i = 0; i < n; i++) begin
            drive_step(0, bit'($urandom), 1'b0, $urandom_range(0, NUM_SRC-1), 1'b0, '0, cap);
        end
    endtask

    // One request on source s whose valid appears d cycles after acceptance
    // (d=0: valid on the request cycle; d>TIMEOUT: never within the window).
    task automatic run_txn(input int s, input int d, input bit fx, input logic [WIDTH-1:0] fv);
        logic [WIDTH-1:0] cap;
        exp_t e;
        drive_step(s, d == 0, 1'b1, s, fx && d == 0, fv, cap);
        for (int j = 1; j <= TIMEOUT && j <= d; j++) begin
            drive_step(s, j == d, 1'b1, (s + 1 + $urandom_range(0, NUM_SRC-2)) % NUM_SRC,
                       fx && j == d, fv, cap);
        end
        e.is_done = (d <= TIMEOUT);
        e.dat     = cap;
        e.sel     = SEL_W'(s);
        e.busy    = (d <= TIMEOUT) ? d : TIMEOUT;
        e.cyc     = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic reset_mid_wait();
        logic [WIDTH-1:0] cap;
        drive_step(2, 1'b0, 1'b1, 2, 1'b0, '0, cap);
        for (int j = 1; j <= 3; j++) begin
            drive_step(2, 1'b0, 1'b1, 0, 1'b0, '0, cap);
        end
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        src_valid_in = '1;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        req_in = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        req_in       = 1'b1;
        sel_A_in     = '0;
        src_in       = '1;
        src_valid_in = '1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        req_in = 1'b0;

        // Back-to-back hits, then slow source, timeout, ignored retarget, and boundaries.
        run_txn(1, 0, 1'b1, 11'h071);
        run_txn(0, 0, 1'b1, 11'h782);
        idle(2);
        run_txn(2, 3, 1'b1, 11'h155);
        run_txn(3, 99, 1'b0, '0);
        run_txn(2, 5, 1'b0, '0);
        run_txn(1, TIMEOUT, 1'b0, '0);
        run_txn(0, TIMEOUT - 1, 1'b0, '0);
        run_txn(3, TIMEOUT + 1, 1'b0, '0);
        run_txn(2, 1, 1'b0, '0);
        idle(2);
        reset_mid_wait();
        idle(4);
        run_txn(1, 0, 1'b0, '0);

        for (int t = 0; t < 150; t++) begin
            int r;
            r = $urandom_range(0, 9);
            run_txn($urandom_range(0, NUM_SRC-1),
                    (r < 4) ? 0 : $urandom_range(1, TIMEOUT + 2), 1'b0, '0);
            idle($urandom_range(0, 2));
        end

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
        idle(2);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
